debug_abstract_cmd_encoder: RTL and testbench

Converts a debug-module "Access Register" abstract command into a short sequence of RV32I/Zicsr instruction words. These words are fed into the core's debug instruction-injection path in place of fetched instructions. It is the encoding counterpart of the core's instruction legality/decode logic, and every word it emits is legal under the base and CSR decode rules. It tracks retirement of each injected word and reports completion or error back to the debug module.

---
 rtl/debug_abstract_cmd_encoder_pkg.sv | 67 ++++++
 rtl/debug_abstract_cmd_encoder_instr_builder.sv | 94 +++++++++
 rtl/debug_abstract_cmd_encoder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_debug_abstract_cmd_encoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_abstract_cmd_encoder_pkg.sv
// -----------------------------------------------------------------------------
// debug_abstract_cmd_encoder_pkg
// Shared debug definitions used by the abstract-command encoder:
//   - abstract command error codes (cmderr_e)
//   - encoder FSM state type (enc_state_e)
//   - GPR abstract register-number base and supported access size
//   - CSR address constants (DSCRATCH0 is the GPR-read transfer register)
//   - RV32I / Zicsr opcode and funct3 constants
//   - instruction-format helper functions (I-type, U-type)
// No ports; package only.
// -----------------------------------------------------------------------------
package debug_abstract_cmd_encoder_pkg;

  // Abstract command error codes reported back to the debug module
  typedef enum logic [2:0] {
    CMDERR_NONE          = 3'd0,
    CMDERR_NOT_SUPPORTED = 3'd2,
    CMDERR_EXCEPTION     = 3'd3
  } cmderr_e;

  // Encoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } enc_state_e;

  // Abstract regno 0x1000..0x101F addresses x0..x31
  localparam logic [15:0] GPR_REGNO_BASE = 16'h1000;
  localparam logic [15:0] GPR_REGNO_MASK = 16'hFFE0;
  localparam logic [2:0]  AARSIZE_32     = 3'd2;

  // CSR address constants
  localparam logic [11:0] CSR_DSCRATCH0  = 12'h7B2;

  // Major opcodes
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // funct3 values
  localparam logic [2:0] F3_ADDI   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_FENCEI = 3'b001;

  // FENCE.I with all other fields zero (32'h0000100F)
  localparam logic [31:0] INSTR_FENCEI = {17'd0, F3_FENCEI, 5'd0, OPC_MISC_MEM};

  // I-type: imm[11:0] | rs1 | funct3 | rd | opcode
  function automatic logic [31:0] enc_i_type(input logic [11:0] imm,
                                             input logic [4:0]  rs1,
                                             input logic [2:0]  f3,
                                             input logic [4:0]  rd,
                                             input logic [6:0]  opc);
    enc_i_type = {imm, rs1, f3, rd, opc};
  endfunction

  // U-type: imm[31:12] | rd | opcode
  function automatic logic [31:0] enc_u_type(input logic [19:0] imm,
                                             input logic [4:0]  rd,
                                             input logic [6:0]  opc);
    enc_u_type = {imm, rd, opc};
  endfunction

endpackage

// File: rtl/debug_abstract_cmd_encoder_instr_builder.sv
// -----------------------------------------------------------------------------
// debug_instr_builder
// Purely combinational. Given a (latched) Access Register command and a word
// index, returns the instruction word at that index and the total number of
// words in the sequence.
//   Read            : CSRRW x0, DSCRATCH, xN
//   Write x0        : no words
//   Write, small    : ADDI xN, x0, imm     (data[31:11] all equal)
//   Write, large    : LUI xN, hi ; ADDI xN, xN, imm
// Optional feature macro: DEBUG_CMD_FENCEI_EN appends FENCE.I to every
// non-empty sequence.
// Ports:
//   i_write  in  1   1 = write GPR, 0 = read GPR
//   i_rd     in  5   GPR index
//   i_data   in  32  write value
//   i_idx    in  2   word index within the sequence
//   o_instr  out 32  instruction word at i_idx
//   o_len    out 2   sequence length in words
// -----------------------------------------------------------------------------
module debug_instr_builder
  import debug_abstract_cmd_encoder_pkg::*;
#(
  parameter logic [11:0] DSCRATCH_ADDR = CSR_DSCRATCH0
) (
  input  logic        i_write,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_idx,
  output logic [31:0] o_instr,
  output logic [1:0]  o_len
);

  logic        w_small;
  logic [19:0] w_hi;
  logic [1:0]  w_base_len;
  logic [31:0] w_word0;
  logic [31:0] w_word1;
  logic [31:0] w_base_instr;

  // Candidate words and base sequence length
  always_comb begin
    // ADDI sign-extends bit 11, so a single ADDI suffices when bits 31:11 agree
    w_small = (&i_data[31:11]) | ~(|i_data[31:11]);
    // (data + 0x800)[31:12]: the carry into bit 12 is exactly data[11]
    w_hi    = i_data[31:12] + {19'd0, i_data[11]};

    if (!i_write) begin
      w_base_len = 2'd1;
      w_word0    = enc_i_type(DSCRATCH_ADDR, i_rd, F3_CSRRW, 5'd0, OPC_SYSTEM);
    end else if (i_rd == 5'd0) begin
      w_base_len = 2'd0;
      w_word0    = 32'd0;
    end else if (w_small) begin
      w_base_len = 2'd1;
      w_word0    = enc_i_type(i_data[11:0], 5'd0, F3_ADDI, i_rd, OPC_OP_IMM);
    end else begin
      w_base_len = 2'd2;
      w_word0    = enc_u_type(w_hi, i_rd, OPC_LUI);
    end
    w_word1 = enc_i_type(i_data[11:0], i_rd, F3_ADDI, i_rd, OPC_OP_IMM);
  end

  // Word selection by index
  always_comb begin
    case (i_idx)
      2'd0:    w_base_instr = w_word0;
      2'd1:    w_base_instr = w_word1;
      default: w_base_instr = 32'd0;
    endcase
  end

`ifdef DEBUG_CMD_FENCEI_EN
  // Append FENCE.I after the last base word of a non-empty sequence
  always_comb begin
    if (w_base_len == 2'd0) begin
      o_len   = 2'd0;
      o_instr = 32'd0;
    end else if (i_idx == w_base_len) begin
      o_len   = w_base_len + 2'd1;
      o_instr = INSTR_FENCEI;
    end else begin
      o_len   = w_base_len + 2'd1;
      o_instr = w_base_instr;
    end
  end
`else
  // Base sequence only
  always_comb begin
    o_len   = w_base_len;
    o_instr = w_base_instr;
  end
`endif

endmodule

// File: rtl/debug_abstract_cmd_encoder.sv
// -----------------------------------------------------------------------------
// debug_abstract_cmd_encoder
// Turns an "Access Register" abstract command into RV32I/Zicsr instruction
// words for the core's debug injection path, tracks their retirement and
// reports completion/error to the debug module.
// Optional feature macro: DEBUG_CMD_FENCEI_EN (FENCE.I appended to every
// non-empty sequence, up to 3 words).
// Ports:
//   clk              in  1   core clock
//   rst              in  1   synchronous active-low reset
//   cmd_valid/ready  in/out  abstract command handshake
//   cmd_regno        in  16  abstract register number
//   cmd_write        in  1   1 = write GPR, 0 = read GPR
//   cmd_aarsize      in  3   access size (only 32-bit supported)
//   cmd_data         in  32  write value
//   instr_valid/ready out/in injected word handshake
//   instr            out 32  injected word
//   instr_retire     in  1   one injected word retired
//   instr_exception  in  1   injected word raised an exception
//   rsp_valid/ready  out/in  response handshake
//   rsp_cmderr       out 3   completion status
// -----------------------------------------------------------------------------
module debug_abstract_cmd_encoder
  import debug_abstract_cmd_encoder_pkg::*;
#(
  parameter logic [11:0] DSCRATCH_ADDR = CSR_DSCRATCH0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_regno,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_aarsize,
  input  logic [31:0] cmd_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  input  logic        instr_retire,
  input  logic        instr_exception,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_cmderr
);

  enc_state_e  r_state;
  enc_state_e  w_state_nxt;

  // Latched command
  logic        r_write;
  logic [4:0]  r_rd;
  logic [31:0] r_data;
  logic [1:0]  r_len;
  logic        w_latch;
  logic [1:0]  w_len_nxt;

  // Progress counters
  logic [1:0]  r_issued;
  logic [1:0]  r_retired;
  logic [1:0]  w_issued_nxt;
  logic [1:0]  w_retired_nxt;
  logic [1:0]  w_issued_inc;
  logic [1:0]  w_retired_inc;

  // Registered outputs
  logic        r_cmd_ready;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic        r_rsp_valid;
  cmderr_e     r_cmderr;
  logic        w_instr_valid_nxt;
  logic [31:0] w_instr_nxt;
  logic        w_rsp_valid_nxt;
  cmderr_e     w_cmderr_nxt;

  // Builder interface
  logic        w_b_write;
  logic [4:0]  w_b_rd;
  logic [31:0] w_b_data;
  logic [1:0]  w_b_idx;
  logic [31:0] w_b_instr;
  logic [1:0]  w_b_len;

  logic        w_supported;
  logic        w_hs;

  // Builder input select: live command while idle so the first word can be
  // registered on the acceptance edge; latched command afterwards
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_b_write = cmd_write;
      w_b_rd    = cmd_regno[4:0];
      w_b_data  = cmd_data;
      w_b_idx   = 2'd0;
    end else begin
      w_b_write = r_write;
      w_b_rd    = r_rd;
      w_b_data  = r_data;
      w_b_idx   = r_issued + 2'd1;
    end
  end

  debug_instr_builder #(
    .DSCRATCH_ADDR (DSCRATCH_ADDR)
  ) u_builder (
    .i_write (w_b_write),
    .i_rd    (w_b_rd),
    .i_data  (w_b_data),
    .i_idx   (w_b_idx),
    .o_instr (w_b_instr),
    .o_len   (w_b_len)
  );

  assign w_supported   = ((cmd_regno & GPR_REGNO_MASK) == GPR_REGNO_BASE) &&
                         (cmd_aarsize == AARSIZE_32);
  assign w_hs          = r_instr_valid & instr_ready;
  assign w_issued_inc  = r_issued + 2'd1;
  assign w_retired_inc = r_retired + {1'b0, instr_retire};

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_latch           = 1'b0;
    w_len_nxt         = r_len;
    w_issued_nxt      = r_issued;
    w_retired_nxt     = r_retired;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_cmderr_nxt      = r_cmderr;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_latch       = 1'b1;
          w_issued_nxt  = 2'd0;
          w_retired_nxt = 2'd0;
          if (!w_supported) begin
            w_state_nxt     = ST_RESP;
            w_len_nxt       = 2'd0;
            w_rsp_valid_nxt = 1'b1;
            w_cmderr_nxt    = CMDERR_NOT_SUPPORTED;
          end else if (w_b_len == 2'd0) begin
            w_state_nxt     = ST_RESP;
            w_len_nxt       = 2'd0;
            w_rsp_valid_nxt = 1'b1;
            w_cmderr_nxt    = CMDERR_NONE;
          end else begin
            w_state_nxt       = ST_ISSUE;
            w_len_nxt         = w_b_len;
            w_instr_valid_nxt = 1'b1;
            w_instr_nxt       = w_b_instr;
          end
        end else begin
          w_latch = 1'b0;
        end
      end

      ST_ISSUE: begin
        // Early retires of already-accepted words are counted here too
        w_retired_nxt = w_retired_inc;
        if (instr_exception) begin
          w_state_nxt       = ST_RESP;
          w_instr_valid_nxt = 1'b0;
          w_instr_nxt       = 32'd0;
          w_rsp_valid_nxt   = 1'b1;
          w_cmderr_nxt      = CMDERR_EXCEPTION;
        end else if (w_hs) begin
          w_issued_nxt = w_issued_inc;
          if (w_issued_inc == r_len) begin
            w_state_nxt       = ST_WAIT;
            w_instr_valid_nxt = 1'b0;
            w_instr_nxt       = 32'd0;
          end else begin
            w_instr_nxt = w_b_instr;
          end
        end else begin
          w_instr_nxt = r_instr;
        end
      end

      ST_WAIT: begin
        // Exception takes priority over a coincident final retire
        if (instr_exception) begin
          w_state_nxt     = ST_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_cmderr_nxt    = CMDERR_EXCEPTION;
        end else if (w_retired_inc == r_issued) begin
          w_state_nxt     = ST_RESP;
          w_retired_nxt   = w_retired_inc;
          w_rsp_valid_nxt = 1'b1;
          w_cmderr_nxt    = CMDERR_NONE;
        end else begin
          w_retired_nxt = w_retired_inc;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_cmderr_nxt    = CMDERR_NONE;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_instr_valid_nxt = 1'b0;
        w_instr_nxt       = 32'd0;
        w_rsp_valid_nxt   = 1'b0;
        w_cmderr_nxt      = CMDERR_NONE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'd0;
      r_rsp_valid   <= 1'b0;
      r_cmderr      <= CMDERR_NONE;
      r_issued      <= 2'd0;
      r_retired     <= 2'd0;
      r_len         <= 2'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= (w_state_nxt == ST_IDLE);
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_cmderr      <= w_cmderr_nxt;
      r_issued      <= w_issued_nxt;
      r_retired     <= w_retired_nxt;
      r_len         <= w_len_nxt;
    end
  end

  // Command latch: captured once at acceptance, insensitive to later cmd_* changes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_rd    <= 5'd0;
      r_data  <= 32'd0;
    end else if (w_latch) begin
      r_write <= cmd_write;
      r_rd    <= cmd_regno[4:0];
      r_data  <= cmd_data;
    end else begin
      r_write <= r_write;
      r_rd    <= r_rd;
      r_data  <= r_data;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_cmderr  = r_cmderr;

endmodule

// File: tb/tb_debug_abstract_cmd_encoder.sv
// -----------------------------------------------------------------------------
// tb_debug_abstract_cmd_encoder
// Table-driven directed bench for debug_abstract_cmd_encoder plus hand-written
// sequences for stall, exception, reset and idle-retire corner cases.
// Honours DEBUG_CMD_FENCEI_EN by appending FENCE.I to expected sequences.
// -----------------------------------------------------------------------------
module tb_debug_abstract_cmd_encoder;

  localparam logic [31:0] FENCEI_W = 32'h0000100F;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_regno;
  logic        cmd_write;
  logic [2:0]  cmd_aarsize;
  logic [31:0] cmd_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_retire;
  logic        instr_exception;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_cmderr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  debug_abstract_cmd_encoder dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_regno       (cmd_regno),
    .cmd_write       (cmd_write),
    .cmd_aarsize     (cmd_aarsize),
    .cmd_data        (cmd_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_retire    (instr_retire),
    .instr_exception (instr_exception),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_cmderr      (rsp_cmderr)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [15:0] regno;
    logic [2:0]  aarsize;
    logic [31:0] data;
    int          n;      // base word count (without FENCE.I)
    logic [31:0] w0;
    logic [31:0] w1;
    logic [2:0]  err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected word list for a vector in the current build
  task automatic exp_words(input vec_t v, output logic [31:0] e0, output logic [31:0] e1,
                           output logic [31:0] e2, output int n);
    logic [31:0] e[3];
    e[0] = v.w0; e[1] = v.w1; e[2] = 32'd0; n = v.n;
`ifdef DEBUG_CMD_FENCEI_EN
    if (n > 0) begin
      e[n] = FENCEI_W;
      n++;
    end
`endif
    e0 = e[0]; e1 = e[1]; e2 = e[2];
  endtask

  // Present a command at the next negedge and let it be accepted on the posedge
  task automatic send_cmd(input vec_t v);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_regno = v.regno;
    cmd_aarsize = v.aarsize; cmd_data = v.data;
    chk({v.name, "_cmd_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: the encoder must use the latched copy
    cmd_valid = 1'b0; cmd_data = ~cmd_data; cmd_regno = 16'h0000; cmd_write = ~cmd_write;
    chk({v.name, "_cmd_ready_busy"}, {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic rsp_handshake(input string name);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_rsp_dropped"}, {31'd0, rsp_valid}, 32'd0);
    chk({name, "_cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Full transaction for one table entry; caller is at a negedge in IDLE
  task automatic run_vec(input vec_t v);
    logic [31:0] e[3];
    int n;
    exp_words(v, e[0], e[1], e[2], n);
    send_cmd(v);
    if (n == 0) begin
      chk({v.name, "_no_instr"}, {31'd0, instr_valid}, 32'd0);
      chk({v.name, "_rsp_T1"}, {31'd0, rsp_valid}, 32'd1);
      chk({v.name, "_cmderr"}, {29'd0, rsp_cmderr}, {29'd0, v.err});
    end else begin
      instr_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        chk($sformatf("%s_valid%0d", v.name, k), {31'd0, instr_valid}, 32'd1);
        chk($sformatf("%s_word%0d", v.name, k), instr, e[k]);
        @(posedge clk);
      end
      @(negedge clk);
      instr_ready = 1'b0;
      chk({v.name, "_valid_off"}, {31'd0, instr_valid}, 32'd0);
      chk({v.name, "_no_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
      for (int k = 0; k < n; k++) begin
        instr_retire = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_retire = 1'b0;
        if (k < n - 1) chk($sformatf("%s_rsp_wait%0d", v.name, k), {31'd0, rsp_valid}, 32'd0);
      end
      chk({v.name, "_rsp"}, {31'd0, rsp_valid}, 32'd1);
      chk({v.name, "_cmderr"}, {29'd0, rsp_cmderr}, {29'd0, v.err});
    end
    rsp_handshake(v.name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e[3];
    int n;

    //            name        wr    regno     aar   data           n  w0            w1            err
    vecs[0]  = '{"rd_x5",    1'b0, 16'h1005, 3'd2, 32'h0,        1, 32'h7B229073, 32'h0,        3'd0};
    vecs[1]  = '{"wr_x5",    1'b1, 16'h1005, 3'd2, 32'h12345FFF, 2, 32'h123462B7, 32'hFFF28293, 3'd0};
    vecs[2]  = '{"wr_x1",    1'b1, 16'h1001, 3'd2, 32'h000007FF, 1, 32'h7FF00093, 32'h0,        3'd0};
    vecs[3]  = '{"wr_x0",    1'b1, 16'h1000, 3'd2, 32'hDEADBEEF, 0, 32'h0,        32'h0,        3'd0};
    vecs[4]  = '{"bad_regno",1'b0, 16'h0300, 3'd2, 32'h0,        0, 32'h0,        32'h0,        3'd2};
    vecs[5]  = '{"bad_size", 1'b1, 16'h1005, 3'd3, 32'h12345678, 0, 32'h0,        32'h0,        3'd2};
    vecs[6]  = '{"wr_x31neg",1'b1, 16'h101F, 3'd2, 32'hFFFFF800, 1, 32'h80000F93, 32'h0,        3'd0};
    vecs[7]  = '{"wr_x10",   1'b1, 16'h100A, 3'd2, 32'h80000000, 2, 32'h80000537, 32'h00050513, 3'd0};
    vecs[8]  = '{"wr_x3cy",  1'b1, 16'h1003, 3'd2, 32'h7FFFF800, 2, 32'h800001B7, 32'h80018193, 3'd0};
    vecs[9]  = '{"rd_x0",    1'b0, 16'h1000, 3'd2, 32'h0,        1, 32'h7B201073, 32'h0,        3'd0};
    vecs[10] = '{"regno_hi", 1'b0, 16'h1020, 3'd2, 32'h0,        0, 32'h0,        32'h0,        3'd2};

    rst = 1'b0; cmd_valid = 1'b0; cmd_regno = 16'h0; cmd_write = 1'b0; cmd_aarsize = 3'd0;
    cmd_data = 32'h0; instr_ready = 1'b0; instr_retire = 1'b0; instr_exception = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_cmderr", {29'd0, rsp_cmderr}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Stall: word must hold while instr_ready is low
    exp_words(vecs[1], e[0], e[1], e[2], n);
    send_cmd(vecs[1]);
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_valid%0d", c), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("stall_word%0d", c), instr, e[0]);
      @(posedge clk);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("stall_word_after%0d", k), instr, e[k]);
      @(posedge clk);
    end
    @(negedge clk);
    instr_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      instr_retire = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_retire = 1'b0;
    end
    chk("stall_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("stall_cmderr", {29'd0, rsp_cmderr}, 32'd0);
    rsp_handshake("stall");

    // Exception on first retire while the second word is pending
    send_cmd(vecs[1]);
    instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_ready = 1'b0;
    chk("exc_word1_pending", instr, 32'hFFF28293);
    instr_retire = 1'b1; instr_exception = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_retire = 1'b0; instr_exception = 1'b0;
    chk("exc_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("exc_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("exc_cmderr", {29'd0, rsp_cmderr}, 32'd3);
    rsp_handshake("exc");

    // Exception together with the final retire: exception wins
    exp_words(vecs[0], e[0], e[1], e[2], n);
    send_cmd(vecs[0]);
    instr_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("excl_word%0d", k), instr, e[k]);
      @(posedge clk);
    end
    @(negedge clk);
    instr_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      instr_retire = 1'b1;
      instr_exception = (k == n - 1) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      instr_retire = 1'b0; instr_exception = 1'b0;
    end
    chk("excl_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("excl_cmderr", {29'd0, rsp_cmderr}, 32'd3);
    rsp_handshake("excl");

    // Reset mid-ISSUE aborts with no response
    send_cmd(vecs[1]);
    chk("rst_pre_valid", {31'd0, instr_valid}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mid_instr", instr, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_cmderr", {29'd0, rsp_cmderr}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Retire pulse while idle must not be counted toward the next command
    instr_retire = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_retire = 1'b0;
    run_vec(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
